// File: rtl/idwt_haar_pipelined_pkg.sv
// Shared constants and controller encoding for the pipelined inverse Haar transform.
// The 1/sqrt(2) scale is Q8 fixed point, so products are shifted right by 8 at store time.
package idwt_haar_pipelined_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int COEF_W       = 16;
  localparam int SUM_W        = COEF_W + 1;
  localparam int PROD_W       = 26;
  localparam int INV_SQRT2_Q8 = 181;

endpackage

// File: rtl/idwt_haar_pipelined_smult_by_181.sv
// Combinational signed multiply by 181 (1/sqrt(2) in Q8) built from shifts and adds.
module smult_by_181
  import idwt_haar_pipelined_pkg::*;
(
  input  logic signed [SUM_W-1:0]  i_x,
  output logic signed [PROD_W-1:0] o_p
);

  logic signed [PROD_W-1:0] w_x;

  assign w_x = {{(PROD_W-SUM_W){i_x[SUM_W-1]}}, i_x};

  // 181 = 128 + 32 + 16 + 4 + 1
  assign o_p = (w_x <<< 7) + (w_x <<< 5) + (w_x <<< 4) + (w_x <<< 2) + w_x;

endmodule

// File: rtl/idwt_haar_pipelined.sv
// One-level inverse Haar DWT: streams N/2 coefficient pairs through a 3-stage pipeline
// (capture, butterfly, scale) and writes each reconstructed sample pair into array_out.
module idwt_haar_pipelined
  import idwt_haar_pipelined_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [COEF_W*(N/2)-1:0]    cA_in,
  input  logic [COEF_W*(N/2)-1:0]    cD_in,
  output logic [COEF_W*N-1:0]        array_out,
  output logic                       busy,
  output logic                       done
);

  localparam int NP    = N / 2;
  localparam int IDX_W = (NP > 1) ? $clog2(NP) : 1;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [IDX_W-1:0]          r_cnt;
  logic                      r_busy;
  logic                      r_done;

  logic                      r_v0;
  logic [IDX_W-1:0]          r_i0;
  logic signed [COEF_W-1:0]  r_a0;
  logic signed [COEF_W-1:0]  r_d0;

  logic                      r_v1;
  logic [IDX_W-1:0]          r_i1;
  logic signed [SUM_W-1:0]   r_s1;
  logic signed [SUM_W-1:0]   r_df1;

  logic                      r_v2;
  logic [IDX_W-1:0]          r_i2;
  logic signed [PROD_W-1:0]  r_ps2;
  logic signed [PROD_W-1:0]  r_pd2;

  logic signed [COEF_W-1:0]  w_ca;
  logic signed [COEF_W-1:0]  w_cd;
  logic signed [PROD_W-1:0]  w_ps;
  logic signed [PROD_W-1:0]  w_pd;
  logic                      w_pipe_empty;
  logic                      w_unused;

  assign w_ca         = cA_in[COEF_W*r_cnt +: COEF_W];
  assign w_cd         = cD_in[COEF_W*r_cnt +: COEF_W];
  assign w_pipe_empty = !(r_v0 || r_v1 || r_v2);
  // Only bits [23:8] of each product form a sample; the rest is headroom and fraction.
  assign w_unused     = ^{r_ps2[PROD_W-1:24], r_ps2[7:0], r_pd2[PROD_W-1:24], r_pd2[7:0]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_LOAD;
      ST_LOAD:  if (r_cnt == IDX_W'(NP - 1)) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_pipe_empty) w_state_next = ST_DONE;
      ST_DONE:  if (!start) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == ST_LOAD) || (w_state_next == ST_DRAIN);
      r_done  <= (w_state_next == ST_DONE);
      if (r_state == ST_LOAD) r_cnt <= r_cnt + 1'b1;
      else                    r_cnt <= '0;
    end
  end

  smult_by_181 u_mult_s (.i_x(r_s1),  .o_p(w_ps));
  smult_by_181 u_mult_d (.i_x(r_df1), .o_p(w_pd));

  // Each stage carries its pair index so the store never depends on controller timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0  <= 1'b0;
      r_i0  <= '0;
      r_a0  <= '0;
      r_d0  <= '0;
      r_v1  <= 1'b0;
      r_i1  <= '0;
      r_s1  <= '0;
      r_df1 <= '0;
      r_v2  <= 1'b0;
      r_i2  <= '0;
      r_ps2 <= '0;
      r_pd2 <= '0;
    end else begin
      r_v0 <= (r_state == ST_LOAD);
      if (r_state == ST_LOAD) begin
        r_i0 <= r_cnt;
        r_a0 <= w_ca;
        r_d0 <= w_cd;
      end
      r_v1  <= r_v0;
      r_i1  <= r_i0;
      r_s1  <= {r_a0[COEF_W-1], r_a0} + {r_d0[COEF_W-1], r_d0};
      r_df1 <= {r_a0[COEF_W-1], r_a0} - {r_d0[COEF_W-1], r_d0};
      r_v2  <= r_v1;
      r_i2  <= r_i1;
      r_ps2 <= w_ps;
      r_pd2 <= w_pd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NP; gi++) begin : g_pair
      logic [COEF_W-1:0] r_lo;
      logic [COEF_W-1:0] r_hi;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_lo <= '0;
          r_hi <= '0;
        end else if (r_v2 && (r_i2 == IDX_W'(gi))) begin
          r_lo <= r_ps2[23:8];
          r_hi <= r_pd2[23:8];
        end
      end

      assign array_out[2*COEF_W*gi          +: COEF_W] = r_lo;
      assign array_out[2*COEF_W*gi + COEF_W +: COEF_W] = r_hi;
    end
  endgenerate

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_idwt_haar_pipelined.sv
// Scoreboard bench: the driver pushes the model's expected output per run, the monitor
// pops and compares it when done rises; the driver checks timing and handshakes.
module tb_idwt_haar_pipelined;

  localparam int N  = 8;
  localparam int NP = N / 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [16*NP-1:0]    cA_in;
  logic [16*NP-1:0]    cD_in;
  logic [16*N-1:0]     array_out;
  logic                busy;
  logic                done;

  idwt_haar_pipelined #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .cA_in(cA_in), .cD_in(cD_in),
    .array_out(array_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              run_id   = 0;
  int              g_ca[NP];
  int              g_cd[NP];
  logic [16*N-1:0] exp_q[$];
  logic [16*N-1:0] last_exp;

  task automatic chk(input string name, input logic [16*N-1:0] act, input logic [16*N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int floor_div256(input int p);
    int q;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    return q;
  endfunction

  // x[2k] = (a+d)/sqrt2, x[2k+1] = (a-d)/sqrt2, with 1/sqrt2 ~ 181/256 and floor rounding.
  function automatic logic [16*N-1:0] ref_idwt();
    logic [16*N-1:0] r;
    r = '0;
    for (int k = 0; k < NP; k++) begin
      r[32*k      +: 16] = 16'(floor_div256((g_ca[k] + g_cd[k]) * 181));
      r[32*k + 16 +: 16] = 16'(floor_div256((g_ca[k] - g_cd[k]) * 181));
    end
    return r;
  endfunction

  task automatic set_all(input int a, input int d);
    for (int k = 0; k < NP; k++) begin
      g_ca[k] = a;
      g_cd[k] = d;
    end
  endtask

  task automatic set_random();
    logic signed [15:0] t;
    for (int k = 0; k < NP; k++) begin
      t = 16'($urandom); g_ca[k] = t;
      t = 16'($urandom); g_cd[k] = t;
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NP; k++) begin
      cA_in[16*k +: 16] = 16'(g_ca[k]);
      cD_in[16*k +: 16] = 16'(g_cd[k]);
    end
  endtask

  task automatic run_case(input bit wiggle);
    int edges;
    int busy_gaps;
    bit got;
    @(negedge clk);
    drive_inputs();
    start    = 1'b1;
    rst      = 1'b0;
    last_exp = ref_idwt();
    exp_q.push_back(last_exp);
    @(posedge clk);
    edges = 0; busy_gaps = 0; got = 1'b0;
    while (!got && edges < 40) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (!busy) busy_gaps++;
        if (wiggle && edges == 1) start = 1'b0;
        if (wiggle && edges == 3) start = 1'b1;
        @(posedge clk);
        edges++;
      end
    end
    chk("done_latency", edges, 8);
    chk("busy_during_run", busy_gaps, 0);
    chk("busy_with_done", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("done_held", done, 1);
      chk("no_rerun", busy, 0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("retain", array_out, last_exp);
    $display("run %0d: done after %0d edges, array_out=0x%0h", run_id, edges, array_out);
    run_id++;
  endtask

  task automatic reset_mid_drain();
    set_random();
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_array", array_out, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_busy", busy, 0);
      chk("rst_hold_array", array_out, 0);
    end
    $display("run %0d: aborted by reset during DRAIN", run_id);
    run_id++;
  endtask

  // Monitor: compare every word on each rising edge of done.
  initial begin : monitor
    logic            done_q;
    logic [16*N-1:0] e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) done_q = 1'b0;
      else begin
        if (done && !done_q) begin
          if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            for (int j = 0; j < N; j++)
              chk($sformatf("word%0d", j), array_out[16*j +: 16], e[16*j +: 16]);
          end
        end
        done_q = done;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst = 1'b1; start = 1'b0; cA_in = '0; cD_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_array", array_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    set_all(181, 0);
    run_case(1'b0);

    g_ca[0] = 256;    g_cd[0] = -256;
    g_ca[1] = -100;   g_cd[1] = -100;
    g_ca[2] = 1000;   g_cd[2] = -3;
    g_ca[3] = -32768; g_cd[3] = 32767;
    run_case(1'b0);
    chk("kat_w0", array_out[15:0],  16'h0000);
    chk("kat_w1", array_out[31:16], 16'h016A);
    chk("kat_w2", array_out[47:32], 16'hFF72);
    chk("kat_w3", array_out[63:48], 16'h0000);

    for (int k = 0; k < NP; k++) begin
      g_ca[k] = 1000 * (k + 1);
      g_cd[k] = 100 * (k + 1) - 250;
    end
    run_case(1'b1);

    set_all(-32768, -32768);
    run_case(1'b0);
    set_all(32767, -32768);
    run_case(1'b0);

    for (int k = 0; k < NP; k++) begin
      g_ca[k] = floor_div256((128 + 128) * 181);
      g_cd[k] = floor_div256((128 - 128) * 181);
    end
    run_case(1'b0);

    for (int r = 0; r < 6; r++) begin
      set_random();
      run_case(r == 2);
    end

    reset_mid_drain();
    set_all(181, 0);
    run_case(1'b0);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
